xbus_sram_ctl: RTL and testbench
================================

# xbus_sram_ctl

Responder for the memory-side request interface driven by the xbus RAM decoder. It accepts 32-bit word read/write requests on the `sdram_*` handshake and executes each as two 16-bit half-word cycles on an external asynchronous SRAM. It reports completion with `sdram_ready` (read) or `sdram_done` (write). It sits between the xbus RAM block and the board SRAM pins.

## Interface
- `ADDR_BITS`, 17, word-address bits backed by SRAM; SRAM half-word address is `ADDR_BITS+1` bits.
- `WAIT`, 2, clocks per half-word strobe (≥1).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sdram_addr`  in  22  word address.
- `sdram_data_out`  in  32  write data.
- `sdram_data_in`  out  32  read data.
- `sdram_req`  in  1  read request, level, held until `sdram_ready`.
- `sdram_write`  in  1  write request, level, held until `sdram_done`.
- `sdram_ready`  out  1  read data valid.
- `sdram_done`  out  1  write complete.
- `sram_a`  out  ADDR_BITS+1  half-word address.
- `sram_d_in`  in  16  pad input data.
- `sram_d_out`  out  16  pad output data.
- `sram_d_oe`  out  1  pad output enable.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low strobes.
- `sram_ub_n`, `sram_lb_n`  out  1 each  byte lanes; both low during any access.

## Operation
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, ACK.
- IDLE:
  - `sdram_write` takes priority over `sdram_req`. On a request, latch the address and write data.
  - Out-of-range address (`sdram_addr >= 2**ADDR_BITS`): go directly to ACK. A read returns `32'hffffffff`; a write is dropped.
  - Otherwise go to RD_LO or WR_LO.
- Address mapping:
  - LO phases use `sram_a = {addr[ADDR_BITS-1:0],1'b0}`.
  - HI phases use `{addr[ADDR_BITS-1:0],1'b1}`.
  - The low half-word is data[15:0].
- Read phase: `ce_n=0`, `oe_n=0`, `d_oe=0` for WAIT cycles. `sram_d_in` is captured on the final edge of the phase.
- Write phase: lasts WAIT+1 cycles.
  - `d_oe=1` and `sram_d_out` are valid for the whole phase.
  - `we_n=0` for the first WAIT cycles, then high for the last cycle (data hold).
  - `ce_n=0` throughout the phase.
- ACK:
  - Assert `sdram_ready` for a read or `sdram_done` for a write.
  - `sdram_data_in` is updated to `{hi,lo}` on entry to ACK.
  - Remain in ACK while `sdram_req | sdram_write` is high; when both are low, go to IDLE.
- `sdram_data_in` holds its value until the next read completes.
- Only one access is executed per request assertion. A request held high does not re-trigger.

## Timing
- Request sampled high at edge E0 (FSM in IDLE).
- Read: `sdram_ready` goes high after edge E0+2·WAIT (WAIT=2 → 4 clocks).
- Write: `sdram_done` goes high after edge E0+2·WAIT+2 (WAIT=2 → 6 clocks).
- Out-of-range access: ready/done high after E0+1.
- ready/done fall on the first edge that samples both requests low. The next request is accepted no earlier than one clock after that edge.
- Reset values:
  - Strobes `ce_n/oe_n/we_n/ub_n/lb_n`: 1.
  - `sram_d_oe`, `sdram_ready`, `sdram_done`: 0.
  - `sdram_data_in`, `sram_a`, `sram_d_out`: 0.
  - FSM: IDLE.
- Reset mid-access:
  - Strobes deassert and `d_oe` drops asynchronously.
  - The partial write may leave the low half-word updated.
  - No ready/done is issued.
- All outputs are registered; no combinational path exists from request inputs to SRAM pins.

## Configuration
- `XBUS_SRAM_RDCACHE_EN`:
  - Defined: a one-word read cache (tag plus 32-bit data plus valid bit) is compiled in.
    - An in-range read whose address matches a valid tag goes IDLE→ACK, with `sdram_ready` high after E0+1 and no SRAM strobes.
    - A completed read fills the cache.
    - Any write to the matching address invalidates it.
    - Reset clears valid.
  - Undefined: the cache logic is absent and every read performs both SRAM phases.

## Test plan
- Write `0x12345678` to word 5 (WAIT=2):
  - `sram_a` is 10 then 11; `sram_d_out` is `0x5678` then `0x1234`.
  - `we_n` low for 2 of 3 cycles in each phase.
  - `sdram_done` rises after 6 clocks.
- Read word 5 back:
  - `sram_a` is 10 then 11; `sdram_data_in == 0x12345678` with `sdram_ready` after 4 clocks.
  - `sdram_ready` holds until `sdram_req` drops, then falls one edge later.
- Read from `sdram_addr = 22'h020000` (ADDR_BITS=17):
  - No strobes; `sdram_data_in == 0xffffffff` and ready after 1 clock.
  - A write to the same address is dropped; done after 1 clock.
- Hold `sdram_req` high for 20 clocks: exactly one SRAM access occurs.
- Assert reset during WR_LO: `we_n/ce_n` go high and `d_oe` goes low immediately, no `sdram_done` is issued, and the FSM is in IDLE after release.
- With `XBUS_SRAM_RDCACHE_EN`:
  - A repeat read of word 5 gives ready after 1 clock with no strobes.
  - After a write of `0xdeadbeef` to word 5, the next read uses SRAM and returns `0xdeadbeef`.

Source files
------------

// File: rtl/xbus_sram_ctl.sv
// xbus_sram_ctl: 32-bit word requests from the xbus RAM decoder executed as two 16-bit async SRAM cycles
// Ports: clk/reset (async, active-high); sdram_* request side (addr, data_out, data_in, req, write,
// ready, done); sram_* pad side (a, d_in, d_out, d_oe, ce_n, oe_n, we_n, ub_n, lb_n).
// Optional XBUS_SRAM_RDCACHE_EN adds a one-word read cache.
module xbus_sram_ctl #(
  parameter int ADDR_BITS = 17,
  parameter int WAIT      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [21:0]          sdram_addr,
  input  logic [31:0]          sdram_data_out,
  output logic [31:0]          sdram_data_in,
  input  logic                 sdram_req,
  input  logic                 sdram_write,
  output logic                 sdram_ready,
  output logic                 sdram_done,
  output logic [ADDR_BITS:0]   sram_a,
  input  logic [15:0]          sram_d_in,
  output logic [15:0]          sram_d_out,
  output logic                 sram_d_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, ACK} state_t;
  localparam int CW = $clog2(WAIT + 2);
  state_t                r_state, w_nxt;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [ADDR_BITS-1:0]  r_addr, w_addr;
  logic [31:0]           r_wdata, w_wdata, w_ack_data, r_data_in;
  logic [15:0]           r_lo, r_d_out;
  logic [ADDR_BITS:0]    r_sram_a;
  logic                  r_rd, r_ready, r_done, r_ce_n, r_oe_n, r_we_n, r_d_oe;
  logic                  w_go, w_oor, w_hit, w_last, w_rd_ph, w_wr_ph, w_hi_ph, w_any;
  assign w_go    = r_state == IDLE && (sdram_req || sdram_write);
  assign w_oor   = (sdram_addr >> ADDR_BITS) != 22'd0;
  assign w_addr  = w_go ? sdram_addr[ADDR_BITS-1:0] : r_addr;
  assign w_wdata = w_go ? sdram_data_out : r_wdata;
  assign w_last  = r_cnt == CW'((r_state == WR_LO || r_state == WR_HI) ? WAIT : WAIT - 1);
`ifdef XBUS_SRAM_RDCACHE_EN
  logic                  r_cv;
  logic [ADDR_BITS-1:0]  r_ctag;
  logic [31:0]           r_cdata;
  assign w_hit      = !sdram_write && !w_oor && r_cv && r_ctag == sdram_addr[ADDR_BITS-1:0];
  assign w_ack_data = w_hit ? r_cdata : 32'hffffffff;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cv    <= 1'b0;
      r_ctag  <= '0;
      r_cdata <= '0;
    end else if (w_go && sdram_write && !w_oor && r_ctag == sdram_addr[ADDR_BITS-1:0]) begin
      r_cv <= 1'b0;
    end else if (r_state == RD_HI && w_last) begin
      r_cv    <= 1'b1;
      r_ctag  <= r_addr;
      r_cdata <= {sram_d_in, r_lo};
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_ack_data = 32'hffffffff;
`endif
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (sdram_req || sdram_write) w_nxt = (w_oor || w_hit) ? ACK : sdram_write ? WR_LO : RD_LO;
      RD_LO:   if (w_last) w_nxt = RD_HI;
      RD_HI:   if (w_last) w_nxt = ACK;
      WR_LO:   if (w_last) w_nxt = WR_HI;
      WR_HI:   if (w_last) w_nxt = ACK;
      ACK:     if (!(sdram_req || sdram_write)) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  // Pin outputs are registered from the next state so strobes align with the phase they belong to.
  assign w_cnt   = (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
  assign w_rd_ph = w_nxt == RD_LO || w_nxt == RD_HI;
  assign w_wr_ph = w_nxt == WR_LO || w_nxt == WR_HI;
  assign w_hi_ph = w_nxt == RD_HI || w_nxt == WR_HI;
  assign w_any   = w_rd_ph || w_wr_ph;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= 1'b0;
      r_lo      <= '0;
      r_data_in <= '0;
      r_sram_a  <= '0;
      r_d_out   <= '0;
      r_d_oe    <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      if (w_go) begin
        r_addr  <= w_addr;
        r_wdata <= sdram_data_out;
        r_rd    <= !sdram_write;
      end
      r_ce_n <= !w_any;
      r_oe_n <= !w_rd_ph;
      // The final write cycle keeps data driven with we_n high for hold time.
      r_we_n <= !(w_wr_ph && w_cnt < CW'(WAIT));
      r_d_oe <= w_wr_ph;
      if (w_any) r_sram_a <= {w_addr, w_hi_ph};
      if (w_wr_ph) r_d_out <= w_hi_ph ? w_wdata[31:16] : w_wdata[15:0];
      if (r_state == RD_LO && w_last) r_lo <= sram_d_in;
      if (r_state == RD_HI && w_last) r_data_in <= {sram_d_in, r_lo};
      else if (w_go && !sdram_write && (w_oor || w_hit)) r_data_in <= w_ack_data;
      // Short-path acks enter ACK on E0, so the ACK state raises ready/done one edge later.
      r_ready <= (r_state == RD_HI && w_last) || (r_state == ACK && r_rd && (sdram_req || sdram_write));
      r_done  <= (r_state == WR_HI && w_last) || (r_state == ACK && !r_rd && (sdram_req || sdram_write));
    end
  end
  assign sdram_data_in = r_data_in;
  assign sdram_ready   = r_ready;
  assign sdram_done    = r_done;
  assign sram_a        = r_sram_a;
  assign sram_d_out    = r_d_out;
  assign sram_d_oe     = r_d_oe;
  assign sram_ce_n     = r_ce_n;
  assign sram_oe_n     = r_oe_n;
  assign sram_we_n     = r_we_n;
  assign sram_ub_n     = r_ce_n;
  assign sram_lb_n     = r_ce_n;
endmodule

// File: tb/tb_xbus_sram_ctl.sv
// tb_xbus_sram_ctl: vector table plus scoreboard bench for xbus_sram_ctl against a behavioural SRAM
module tb_xbus_sram_ctl;
  localparam int AB = 17;
  localparam int W  = 2;
`ifdef XBUS_SRAM_RDCACHE_EN
  localparam int HL = 1, HC = 0;
`else
  localparam int HL = 4, HC = 4;
`endif
  logic        clk = 1'b0, reset = 1'b1;
  logic [21:0] sdram_addr = '0;
  logic [31:0] sdram_data_out = '0, sdram_data_in;
  logic        sdram_req = 1'b0, sdram_write = 1'b0, sdram_ready, sdram_done;
  logic [AB:0] sram_a;
  logic [15:0] sram_d_in, sram_d_out;
  logic        sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  xbus_sram_ctl #(.ADDR_BITS(AB), .WAIT(W)) dut (
    .clk(clk), .reset(reset), .sdram_addr(sdram_addr), .sdram_data_out(sdram_data_out),
    .sdram_data_in(sdram_data_in), .sdram_req(sdram_req), .sdram_write(sdram_write),
    .sdram_ready(sdram_ready), .sdram_done(sdram_done), .sram_a(sram_a), .sram_d_in(sram_d_in),
    .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [0:(1<<(AB+1))-1];
  assign sram_d_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 16'h0bad;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n && sram_d_oe) mem[sram_a] <= sram_d_out;
  int ce_cnt, we_cnt, done_cnt;
  logic [AB:0] lo_a, hi_a;
  always @(posedge clk) begin
    if (!sram_ce_n) begin
      ce_cnt = ce_cnt + 1;
      if (sram_a[0]) hi_a = sram_a;
      else lo_a = sram_a;
    end
    if (!sram_we_n) we_cnt = we_cnt + 1;
    if (sdram_done) done_cnt = done_cnt + 1;
  end
  int checks = 0, errors = 0;
  logic [31:0] sb [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  typedef struct {
    bit          wr;
    logic [21:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    int          ce;
    int          we;
  } vec_t;
  vec_t vt [13];
  task automatic xfer(input vec_t v);
    int lat;
    logic [31:0] exp;
    @(negedge clk);
    ce_cnt = 0;
    we_cnt = 0;
    lo_a = '1;
    hi_a = '1;
    sdram_addr = v.addr;
    sdram_data_out = v.wd;
    if (v.wr) sdram_write = 1'b1;
    else begin
      sdram_req = 1'b1;
      sb.push_back(v.rd);
    end
    @(posedge clk);
    lat = 0;
    while (!(v.wr ? sdram_done : sdram_ready) && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(v.wr ? "wr_latency" : "rd_latency", lat, v.lat);
    if (!v.wr) begin
      exp = sb.pop_front();
      chk("rd_data", sdram_data_in, exp);
    end
    chk("ce_cycles", ce_cnt, v.ce);
    chk("we_cycles", we_cnt, v.we);
    if (v.ce > 0) begin
      chk("sram_a_lo", 32'(lo_a), 32'({v.addr[AB-1:0], 1'b0}));
      chk("sram_a_hi", 32'(hi_a), 32'({v.addr[AB-1:0], 1'b1}));
    end
    @(posedge clk);
    #1;
    chk("ack_hold", v.wr ? sdram_done : sdram_ready, 1);
    @(negedge clk);
    sdram_req = 1'b0;
    sdram_write = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_fall", {sdram_ready, sdram_done}, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{1'b1, 22'd5,       32'h12345678, 32'h0,        6,  6,  4};
    vt[1]  = '{1'b0, 22'd5,       32'h0,        32'h12345678, 4,  4,  0};
    vt[2]  = '{1'b0, 22'd5,       32'h0,        32'h12345678, HL, HC, 0};
    vt[3]  = '{1'b1, 22'd5,       32'hdeadbeef, 32'h0,        6,  6,  4};
    vt[4]  = '{1'b0, 22'd5,       32'h0,        32'hdeadbeef, 4,  4,  0};
    vt[5]  = '{1'b1, 22'd0,       32'ha5a50001, 32'h0,        6,  6,  4};
    vt[6]  = '{1'b0, 22'd0,       32'h0,        32'ha5a50001, 4,  4,  0};
    vt[7]  = '{1'b1, 22'h01ffff,  32'hcafef00d, 32'h0,        6,  6,  4};
    vt[8]  = '{1'b0, 22'h01ffff,  32'h0,        32'hcafef00d, 4,  4,  0};
    vt[9]  = '{1'b0, 22'h020000,  32'h0,        32'hffffffff, 1,  0,  0};
    vt[10] = '{1'b1, 22'h020000,  32'h11111111, 32'h0,        1,  0,  0};
    vt[11] = '{1'b0, 22'h3fffff,  32'h0,        32'hffffffff, 1,  0,  0};
    vt[12] = '{1'b0, 22'd0,       32'h0,        32'ha5a50001, 4,  4,  0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    chk("rst_ctl", {sram_d_oe, sdram_ready, sdram_done}, 0);
    chk("rst_data_in", sdram_data_in, 0);
    chk("rst_sram_a", 32'(sram_a), 0);
    chk("rst_d_out", 32'(sram_d_out), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 13; i++) xfer(vt[i]);
    // Request held for 20 clocks: a single access only; cache tag is word 0 here so 0x1ffff misses.
    @(negedge clk);
    ce_cnt = 0;
    sdram_addr = 22'h01ffff;
    sdram_req = 1'b1;
    sb.push_back(32'hcafef00d);
    repeat (20) @(posedge clk);
    #1;
    chk("hold_ce_cycles", ce_cnt, 2 * W);
    chk("hold_ready", sdram_ready, 1);
    chk("hold_data", sdram_data_in, sb.pop_front());
    @(negedge clk);
    sdram_req = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_fall", sdram_ready, 0);
    // Reset asserted in the middle of WR_LO.
    @(negedge clk);
    done_cnt = 0;
    sdram_addr = 22'd7;
    sdram_data_out = 32'h77778888;
    sdram_write = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("wr_lo_we", sram_we_n, 0);
    reset = 1'b1;
    #1;
    chk("rst_async", {sram_ce_n, sram_we_n, sram_d_oe}, 3'b110);
    sdram_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ce_cnt = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_done", done_cnt, 0);
    chk("post_rst_idle", ce_cnt, 0);
    xfer('{1'b0, 22'd5, 32'h0, 32'hdeadbeef, 4, 4, 0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
